// File: rtl/lsu_mem_responder_pkg.sv
// Shared types and helpers for the LSU data-side memory responder.
// Holds the response entry layout, the address range check and the byte-lane mask expansion.
package lsu_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } resp_entry_t;

    // base is aligned to size, so masking off the offset bits must reproduce base exactly
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base,
                                           input logic [ADDR_W-1:0] size);
        return (addr & ~(size - 32'd1)) == base;
    endfunction

    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/lsu_mem_responder_if.sv
// Core data-port bundle: request/grant handshake towards the responder, rvalid/rdata/err back.
// master = core side, slave = responder side; gnt_stall_i is an injected back-pressure control.
interface lsu_mem_responder_if
    import lsu_mem_pkg::*;
;
    logic              req_i;
    logic              we_i;
    logic [BE_W-1:0]   be_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              gnt_stall_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, gnt_stall_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, gnt_stall_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/lsu_mem_responder_delay.sv
// Fixed-latency response pipe: LATENCY register stages of {valid, entry}; last stage is the response.
// Cannot be stalled; empty stages carry all-zero data so idle outputs read as 0.
module lsu_resp_delay
    import lsu_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        vld_i,
    input  resp_entry_t dat_i,
    output logic        vld_o,
    output resp_entry_t dat_o
);

    logic        [LATENCY-1:0] vld_q;
    resp_entry_t [LATENCY-1:0] dat_q;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= vld_i ? dat_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[LATENCY-1];
    assign dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/lsu_mem_responder.sv
// LSU data responder: word SRAM behind req/gnt/rvalid, in-order responses LATENCY cycles after grant.
// gnt_o is combinational and drops under gnt_stall_i or when MAX_OUTSTANDING slots are in use.
module lsu_mem_responder
    import lsu_mem_pkg::*;
#(
    parameter int unsigned       MEM_SIZE        = 8192,
    parameter logic [ADDR_W-1:0] MEM_START       = 32'h0000_0000,
    parameter int unsigned       LATENCY         = 1,
    parameter int unsigned       MAX_OUTSTANDING = 2
) (
    input logic                clk_sys,
    input logic                rst_sys_n,
    lsu_mem_responder_if.slave bus
);

    localparam int unsigned DEPTH = MEM_SIZE / 4;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  pending_q;
    logic [CNT_W-1:0]  pending_d;
    logic [CNT_W:0]    occupancy;

    logic              in_range;
    logic              room;
    logic              gnt;
    logic              retire;
    logic [ADDR_W-1:0] word_off;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wr_mask;
    logic              unused_word_off;

    resp_entry_t       entry_d;
    resp_entry_t       rsp_dat;
    logic              rsp_vld;

    assign in_range        = addr_in_range(bus.addr_i, MEM_START, ADDR_W'(MEM_SIZE));
    assign word_off        = (bus.addr_i - MEM_START) >> 2;
    assign idx             = word_off[IDX_W-1:0];
    assign unused_word_off = ^word_off[ADDR_W-1:IDX_W];
    assign wr_mask         = be_to_mask(bus.be_i);

    // A slot retiring this cycle frees room for a grant in the same cycle
    assign retire    = rsp_vld;
    assign occupancy = {1'b0, pending_q} - {{CNT_W{1'b0}}, retire};
    assign room      = occupancy < (CNT_W+1)'(MAX_OUTSTANDING);
    assign gnt       = bus.req_i & ~bus.gnt_stall_i & rst_sys_n & room;

    always_comb begin
        pending_d = pending_q;
        case ({gnt, retire})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Array contents survive reset; gnt is already forced low while reset is asserted
    always_ff @(posedge clk_sys) begin
        if (gnt && bus.we_i && in_range) begin
            mem_q[idx] <= (mem_q[idx] & ~wr_mask) | (bus.wdata_i & wr_mask);
        end
    end

    always_comb begin
        entry_d = '0;
        if (!in_range) begin
            entry_d.err = 1'b1;
        end else if (!bus.we_i) begin
            entry_d.rdata = mem_q[idx];
        end
    end

    lsu_resp_delay #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .vld_i     (gnt),
        .dat_i     (entry_d),
        .vld_o     (rsp_vld),
        .dat_o     (rsp_dat)
    );

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rsp_vld;
    assign bus.rdata_o  = rsp_dat.rdata;
    assign bus.err_o    = rsp_dat.err;

endmodule
